// File: rtl/pcie_axi_pkg.sv
// Shared AXI types for the PCIe-to-AXI bridge targets: burst/response encodings, FSM states,
// and the protocol-error predicate used by both engines of the RAM responder.
package pcie_axi_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10,
    BurstRsvd  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } resp_t;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t WrIdle = 2'd0;
  localparam wr_state_t WrData = 2'd1;
  localparam wr_state_t WrResp = 2'd2;

  typedef logic [0:0] rd_state_t;
  localparam rd_state_t RdIdle = 1'b0;
  localparam rd_state_t RdData = 1'b1;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Burst-level protocol errors, known as soon as the address phase is accepted.
  function automatic logic burst_err(input burst_t burst, input logic [7:0] len,
                                     input logic [2:0] size, input logic [2:0] max_size);
    return (size > max_size) || (burst == BurstRsvd) ||
           ((burst == BurstWrap) && !wrap_len_ok(len));
  endfunction

endpackage

// File: rtl/axi_ram_responder_if.sv
// AXI4 bus bundle between the bridge master and the RAM responder.
interface axi_ram_responder_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts.
// RSVD bursts and WRAP bursts with an illegal length advance like INCR.
module axi_burst_addr
  import pcie_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  burst_t                burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  assign incr      = ADDR_WIDTH'(1) << size_i;
  assign incr_addr = addr_i + incr;
  // Wrap window is (len+1) beats of 2^size bytes, aligned to its own size.
  assign wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);

  always_comb begin
    next_addr_o = incr_addr;
    unique case (burst_i)
      BurstFixed: next_addr_o = addr_i;
      BurstWrap: begin
        if (wrap_len_ok(len_i)) begin
          next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
        end
      end
      default: next_addr_o = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 slave RAM model with independent single-outstanding write and read engines.
// Define AXI_RAM_DECERR_EN to return DECERR for beats beyond DEPTH instead of aliasing.
module axi_ram_responder
  import pcie_axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DEPTH      = 1024
) (
  input logic               clk,
  input logic               rst_n,
  axi_ram_responder_if.slave s_axi
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFF_W      = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam int unsigned WA_W       = ADDR_WIDTH - OFF_W;
  localparam logic [2:0]  MAX_SIZE   = 3'(OFF_W);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write engine ----------------
  wr_state_t             wr_state_q, wr_state_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d, wr_id_q, wr_id_d;
  resp_t                 bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, wr_next_addr;
  logic [7:0]            wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
  logic [2:0]            wr_size_q, wr_size_d;
  burst_t                wr_burst_q, wr_burst_d;
  logic                  wr_slverr_q, wr_slverr_d, wr_decerr_q, wr_decerr_d;

  logic            aw_hs, w_hs, wr_beat_last, wr_beat_slverr, wr_beat_decerr, wr_oob, wr_en;
  logic [WA_W-1:0] wr_word;
  logic [IDX_W-1:0] wr_idx;

  assign aw_hs        = s_axi.awvalid & awready_q;
  assign w_hs         = s_axi.wvalid & wready_q;
  assign wr_beat_last = (wr_cnt_q == wr_len_q);
  assign wr_word      = wr_addr_q[ADDR_WIDTH-1:OFF_W];
  assign wr_idx       = IDX_W'(32'(wr_word) % DEPTH);
`ifdef AXI_RAM_DECERR_EN
  assign wr_oob       = (32'(wr_word) >= DEPTH);
`else
  assign wr_oob       = 1'b0;
`endif
  assign wr_beat_slverr = wr_slverr_q | (s_axi.wlast != wr_beat_last);
  assign wr_beat_decerr = wr_decerr_q | wr_oob;
  // Oversized beats are consumed but never touch the array.
  assign wr_en        = w_hs & (wr_size_q <= MAX_SIZE) & ~wr_oob;

  axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_addr (
    .addr_i      (wr_addr_q),
    .len_i       (wr_len_q),
    .size_i      (wr_size_q),
    .burst_i     (wr_burst_q),
    .next_addr_o (wr_next_addr)
  );

  always_comb begin
    wr_state_d  = wr_state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    wr_id_d     = wr_id_q;
    wr_addr_d   = wr_addr_q;
    wr_len_d    = wr_len_q;
    wr_cnt_d    = wr_cnt_q;
    wr_size_d   = wr_size_q;
    wr_burst_d  = wr_burst_q;
    wr_slverr_d = wr_slverr_q;
    wr_decerr_d = wr_decerr_q;
    unique case (wr_state_q)
      WrIdle: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          awready_d   = 1'b0;
          wready_d    = 1'b1;
          wr_state_d  = WrData;
          wr_id_d     = s_axi.awid;
          wr_addr_d   = s_axi.awaddr;
          wr_len_d    = s_axi.awlen;
          wr_size_d   = s_axi.awsize;
          wr_burst_d  = burst_t'(s_axi.awburst);
          wr_cnt_d    = 8'd0;
          wr_slverr_d = burst_err(burst_t'(s_axi.awburst), s_axi.awlen, s_axi.awsize, MAX_SIZE);
          wr_decerr_d = 1'b0;
        end
      end
      WrData: begin
        if (w_hs) begin
          wr_addr_d   = wr_next_addr;
          wr_cnt_d    = wr_cnt_q + 8'd1;
          wr_slverr_d = wr_beat_slverr;
          wr_decerr_d = wr_beat_decerr;
          // Beat count, not wlast, closes the burst.
          if (wr_beat_last) begin
            wready_d   = 1'b0;
            bvalid_d   = 1'b1;
            bid_d      = wr_id_q;
            bresp_d    = wr_beat_decerr ? RespDecerr : (wr_beat_slverr ? RespSlverr : RespOkay);
            wr_state_d = WrResp;
          end
        end
      end
      WrResp: begin
        if (s_axi.bready) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wr_state_d = WrIdle;
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  // ---------------- read engine ----------------
  rd_state_t             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, rd_next_addr;
  logic [7:0]            rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
  logic [2:0]            rd_size_q, rd_size_d;
  burst_t                rd_burst_q, rd_burst_d;
  logic                  rd_slverr_q, rd_slverr_d;

  logic                  ar_hs, r_hs, rd_idle, fetch_slverr, fetch_oob;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [2:0]            fetch_size;
  logic [WA_W-1:0]       fetch_word;
  logic [IDX_W-1:0]      fetch_idx;
  logic [DATA_WIDTH-1:0] fetch_data;
  resp_t                 fetch_resp;

  assign ar_hs   = s_axi.arvalid & arready_q;
  assign r_hs    = rvalid_q & s_axi.rready;
  assign rd_idle = (rd_state_q == RdIdle);

  axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_addr (
    .addr_i      (rd_addr_q),
    .len_i       (rd_len_q),
    .size_i      (rd_size_q),
    .burst_i     (rd_burst_q),
    .next_addr_o (rd_next_addr)
  );

  // The word loaded into rdata is either the first beat (from AR) or the next beat.
  assign fetch_addr   = rd_idle ? s_axi.araddr : rd_next_addr;
  assign fetch_size   = rd_idle ? s_axi.arsize : rd_size_q;
  assign fetch_slverr = rd_idle ?
      burst_err(burst_t'(s_axi.arburst), s_axi.arlen, s_axi.arsize, MAX_SIZE) : rd_slverr_q;
  assign fetch_word   = fetch_addr[ADDR_WIDTH-1:OFF_W];
  assign fetch_idx    = IDX_W'(32'(fetch_word) % DEPTH);
`ifdef AXI_RAM_DECERR_EN
  assign fetch_oob    = (32'(fetch_word) >= DEPTH);
`else
  assign fetch_oob    = 1'b0;
`endif
  assign fetch_data   = (fetch_oob || (fetch_size > MAX_SIZE)) ? '0 : mem[fetch_idx];
  assign fetch_resp   = fetch_oob ? RespDecerr : (fetch_slverr ? RespSlverr : RespOkay);

  always_comb begin
    rd_state_d  = rd_state_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rid_d       = rid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rd_addr_d   = rd_addr_q;
    rd_len_d    = rd_len_q;
    rd_cnt_d    = rd_cnt_q;
    rd_size_d   = rd_size_q;
    rd_burst_d  = rd_burst_q;
    rd_slverr_d = rd_slverr_q;
    unique case (rd_state_q)
      RdIdle: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d   = 1'b0;
          rvalid_d    = 1'b1;
          rid_d       = s_axi.arid;
          rd_addr_d   = s_axi.araddr;
          rd_len_d    = s_axi.arlen;
          rd_size_d   = s_axi.arsize;
          rd_burst_d  = burst_t'(s_axi.arburst);
          rd_cnt_d    = 8'd0;
          rd_slverr_d = fetch_slverr;
          rlast_d     = (s_axi.arlen == 8'd0);
          rdata_d     = fetch_data;
          rresp_d     = fetch_resp;
          rd_state_d  = RdData;
        end
      end
      RdData: begin
        if (r_hs) begin
          if (rlast_q) begin
            rvalid_d   = 1'b0;
            rlast_d    = 1'b0;
            arready_d  = 1'b1;
            rd_state_d = RdIdle;
          end else begin
            rd_addr_d = rd_next_addr;
            rd_cnt_d  = rd_cnt_q + 8'd1;
            rlast_d   = ((rd_cnt_q + 8'd1) == rd_len_q);
            rdata_d   = fetch_data;
            rresp_d   = fetch_resp;
          end
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q  <= WrIdle;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= RespOkay;
      wr_id_q     <= '0;
      wr_addr_q   <= '0;
      wr_len_q    <= '0;
      wr_cnt_q    <= '0;
      wr_size_q   <= '0;
      wr_burst_q  <= BurstFixed;
      wr_slverr_q <= 1'b0;
      wr_decerr_q <= 1'b0;
      rd_state_q  <= RdIdle;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rid_q       <= '0;
      rdata_q     <= '0;
      rresp_q     <= RespOkay;
      rd_addr_q   <= '0;
      rd_len_q    <= '0;
      rd_cnt_q    <= '0;
      rd_size_q   <= '0;
      rd_burst_q  <= BurstFixed;
      rd_slverr_q <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      wr_id_q     <= wr_id_d;
      wr_addr_q   <= wr_addr_d;
      wr_len_q    <= wr_len_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_size_q   <= wr_size_d;
      wr_burst_q  <= wr_burst_d;
      wr_slverr_q <= wr_slverr_d;
      wr_decerr_q <= wr_decerr_d;
      rd_state_q  <= rd_state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rid_q       <= rid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rd_addr_q   <= rd_addr_d;
      rd_len_q    <= rd_len_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_size_q   <= rd_size_d;
      rd_burst_q  <= rd_burst_d;
      rd_slverr_q <= rd_slverr_d;
    end
  end

  // Array is never reset; a same-edge read samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
        if (s_axi.wstrb[b]) begin
          mem[wr_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
        end
      end
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rlast_q;

  logic unused_attr;
  assign unused_attr = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                         s_axi.arlock, s_axi.arcache, s_axi.arprot};

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed self-checking bench for axi_ram_responder (default build; DECERR path under
// AXI_RAM_DECERR_EN).
module tb_axi_ram_responder;
  import pcie_axi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi_ram_responder_if #(.DATA_WIDTH(64), .ADDR_WIDTH(16), .ID_WIDTH(8)) ifc ();

  axi_ram_responder #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (16),
    .ID_WIDTH   (8),
    .DEPTH      (1024)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_axi (ifc)
  );

  logic [63:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  logic [7:0]  rd_id;
  int          rd_n;
  int          stall_bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [7:0] id);
    logic hs;
    hs = 1'b0;
    ifc.awaddr = addr; ifc.awlen = len; ifc.awsize = size; ifc.awburst = burst; ifc.awid = id;
    ifc.awvalid = 1'b1;
    for (int t = 0; t < 50 && !hs; t++) begin
      hs = ifc.awready;
      tick();
    end
    ifc.awvalid = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL aw_timeout got no awready want awready within 50 cycles");
    end
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    logic hs;
    hs = 1'b0;
    ifc.wdata = data; ifc.wstrb = strb; ifc.wlast = last; ifc.wvalid = 1'b1;
    for (int t = 0; t < 50 && !hs; t++) begin
      hs = ifc.wready;
      tick();
    end
    ifc.wvalid = 1'b0; ifc.wlast = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL w_timeout got no wready want wready within 50 cycles");
    end
  endtask

  task automatic send_ar(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [7:0] id);
    logic hs;
    hs = 1'b0;
    ifc.araddr = addr; ifc.arlen = len; ifc.arsize = size; ifc.arburst = burst; ifc.arid = id;
    ifc.arvalid = 1'b1;
    for (int t = 0; t < 50 && !hs; t++) begin
      hs = ifc.arready;
      tick();
    end
    ifc.arvalid = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL ar_timeout got no arready want arready within 50 cycles");
    end
  endtask

  task automatic get_b(output logic [1:0] resp, output logic [7:0] id);
    logic seen;
    seen = 1'b0; resp = 2'bxx; id = 8'hxx;
    ifc.bready = 1'b1;
    for (int t = 0; t < 50 && !seen; t++) begin
      if (ifc.bvalid) begin
        resp = ifc.bresp; id = ifc.bid; seen = 1'b1;
      end
      tick();
    end
    ifc.bready = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL b_timeout got no bvalid want bvalid within 50 cycles");
    end
  endtask

  // Collects beats into rd_* arrays; stall_bad counts R changes while stalled.
  task automatic read_burst(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic toggle);
    logic [63:0] hold_data;
    logic        hold_last, have_hold, ph;
    rd_n = 0; stall_bad = 0; have_hold = 1'b0; ph = 1'b0;
    hold_data = '0; hold_last = 1'b0;
    send_ar(addr, len, 3'd3, burst, 8'h3C);
    for (int t = 0; t < 200 && rd_n <= int'(len); t++) begin
      ifc.rready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (ifc.rvalid) begin
        if (have_hold && (ifc.rdata !== hold_data || ifc.rlast !== hold_last)) stall_bad++;
        if (ifc.rready) begin
          rd_data[rd_n] = ifc.rdata; rd_last[rd_n] = ifc.rlast; rd_resp[rd_n] = ifc.rresp;
          rd_id = ifc.rid;
          rd_n++;
          have_hold = 1'b0;
        end else begin
          hold_data = ifc.rdata; hold_last = ifc.rlast; have_hold = 1'b1;
        end
      end
      tick();
    end
    ifc.rready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({ifc.awready, ifc.wready, ifc.bvalid, ifc.arready, ifc.rvalid, ifc.rlast} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshake got %b want 000000",
               {ifc.awready, ifc.wready, ifc.bvalid, ifc.arready, ifc.rvalid, ifc.rlast});
    end
    checks++;
    if ({ifc.bid, ifc.rid, ifc.bresp, ifc.rresp, ifc.rdata} !== 84'd0) begin
      errors++;
      $display("FAIL reset_data got bid=%h rid=%h bresp=%b rresp=%b rdata=%h want all zero",
               ifc.bid, ifc.rid, ifc.bresp, ifc.rresp, ifc.rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (ifc.awready !== 1'b1 || ifc.arready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got awready=%b arready=%b want 1 1", ifc.awready, ifc.arready);
    end
  endtask

  task automatic test_incr();
    logic [1:0] resp;
    logic [7:0] id;
    logic [63:0] exp [4];
    exp[0] = 64'h11; exp[1] = 64'h22; exp[2] = 64'h33; exp[3] = 64'h44;
    send_aw(16'h0100, 8'd3, 3'd3, 2'b01, 8'h5A);
    for (int i = 0; i < 4; i++) send_w(exp[i], 8'hFF, i == 3);
    checks++;
    if (ifc.bvalid !== 1'b1 || ifc.bresp !== 2'b00) begin
      errors++;
      $display("FAIL incr_b_latency got bvalid=%b bresp=%b want 1 00", ifc.bvalid, ifc.bresp);
    end
    get_b(resp, id);
    checks++;
    if (resp !== 2'b00 || id !== 8'h5A) begin
      errors++;
      $display("FAIL incr_bresp got resp=%b id=%h want 00 5a", resp, id);
    end
    read_burst(16'h0100, 8'd3, 2'b01, 1'b0);
    checks++;
    if (rd_n !== 4 || rd_id !== 8'h3C) begin
      errors++;
      $display("FAIL incr_rd_count got beats=%0d rid=%h want 4 3c", rd_n, rd_id);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp[i] || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'b00) begin
        errors++;
        $display("FAIL incr_rd_beat%0d got data=%h last=%b resp=%b want %h %b 00",
                 i, rd_data[i], rd_last[i], rd_resp[i], exp[i], i == 3);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] resp;
    logic [7:0] id;
    logic [63:0] exp [4];
    send_aw(16'h0118, 8'd3, 3'd3, 2'b10, 8'h21);
    for (int i = 0; i < 4; i++) send_w(64'hA0 + 64'(i), 8'hFF, i == 3);
    get_b(resp, id);
    checks++;
    if (resp !== 2'b00) begin
      errors++; $display("FAIL wrap_bresp got %b want 00", resp);
    end
    // 0x118 <- A0, 0x100 <- A1, 0x108 <- A2, 0x110 <- A3
    exp[0] = 64'hA1; exp[1] = 64'hA2; exp[2] = 64'hA3; exp[3] = 64'hA0;
    read_burst(16'h0100, 8'd3, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp[i]) begin
        errors++; $display("FAIL wrap_incr_rd%0d got %h want %h", i, rd_data[i], exp[i]);
      end
    end
    read_burst(16'h0118, 8'd3, 2'b10, 1'b0);
    checks++;
    if (rd_data[0] !== 64'hA0 || rd_data[1] !== 64'hA1 || rd_data[3] !== 64'hA3) begin
      errors++;
      $display("FAIL wrap_wrap_rd got %h %h %h want a0 a1 a3", rd_data[0], rd_data[1], rd_data[3]);
    end
  endtask

  task automatic test_rready_toggle();
    logic [1:0] resp;
    logic [7:0] id;
    send_aw(16'h0400, 8'd7, 3'd3, 2'b01, 8'h02);
    for (int i = 0; i < 8; i++) send_w(64'h1000 + 64'(i), 8'hFF, i == 7);
    get_b(resp, id);
    read_burst(16'h0400, 8'd7, 2'b01, 1'b1);
    checks++;
    if (rd_n !== 8 || stall_bad !== 0) begin
      errors++;
      $display("FAIL toggle_count got beats=%0d stall_changes=%0d want 8 0", rd_n, stall_bad);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_data[i] !== 64'h1000 + 64'(i) || rd_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL toggle_beat%0d got data=%h last=%b want %h %b",
                 i, rd_data[i], rd_last[i], 64'h1000 + 64'(i), i == 7);
      end
    end
  endtask

  task automatic test_strobe_and_errors();
    logic [1:0] resp;
    logic [7:0] id;
    send_aw(16'h0300, 8'd0, 3'd3, 2'b01, 8'h01);
    send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    get_b(resp, id);
    send_aw(16'h0300, 8'd0, 3'd3, 2'b01, 8'h01);
    send_w(64'h1234_5678_9ABC_DEF0, 8'h0F, 1'b1);
    get_b(resp, id);
    read_burst(16'h0300, 8'd0, 2'b01, 1'b0);
    checks++;
    if (rd_data[0] !== 64'hFFFF_FFFF_9ABC_DEF0) begin
      errors++; $display("FAIL strobe_rd got %h want ffffffff9abcdef0", rd_data[0]);
    end
    send_aw(16'h0500, 8'd3, 3'd3, 2'b01, 8'h77);
    for (int i = 0; i < 4; i++) send_w(64'h0, 8'hFF, i == 1);
    get_b(resp, id);
    checks++;
    if (resp !== 2'b10 || id !== 8'h77) begin
      errors++; $display("FAIL early_wlast got resp=%b id=%h want 10 77", resp, id);
    end
    send_aw(16'h0600, 8'd2, 3'd3, 2'b10, 8'h78);
    for (int i = 0; i < 3; i++) send_w(64'h0, 8'hFF, i == 2);
    get_b(resp, id);
    checks++;
    if (resp !== 2'b10) begin
      errors++; $display("FAIL wrap_bad_len got resp=%b want 10", resp);
    end
  endtask

  task automatic test_read_before_write();
    logic [1:0] resp;
    logic [7:0] id;
    send_aw(16'h0200, 8'd0, 3'd3, 2'b01, 8'h09);
    send_w(64'hAA, 8'hFF, 1'b1);
    get_b(resp, id);
    send_aw(16'h0200, 8'd0, 3'd3, 2'b01, 8'h0A);
    checks++;
    if (ifc.wready !== 1'b1 || ifc.arready !== 1'b1) begin
      errors++;
      $display("FAIL rbw_setup got wready=%b arready=%b want 1 1", ifc.wready, ifc.arready);
    end
    ifc.wdata = 64'hBB; ifc.wstrb = 8'hFF; ifc.wlast = 1'b1; ifc.wvalid = 1'b1;
    ifc.araddr = 16'h0200; ifc.arlen = 8'd0; ifc.arsize = 3'd3; ifc.arburst = 2'b01;
    ifc.arid = 8'h0B; ifc.arvalid = 1'b1;
    tick();
    ifc.wvalid = 1'b0; ifc.wlast = 1'b0; ifc.arvalid = 1'b0;
    checks++;
    if (ifc.rvalid !== 1'b1 || ifc.rdata !== 64'hAA || ifc.rlast !== 1'b1) begin
      errors++;
      $display("FAIL rbw_old got rvalid=%b rdata=%h rlast=%b want 1 aa 1",
               ifc.rvalid, ifc.rdata, ifc.rlast);
    end
    ifc.rready = 1'b1;
    tick();
    ifc.rready = 1'b0;
    get_b(resp, id);
    read_burst(16'h0200, 8'd0, 2'b01, 1'b0);
    checks++;
    if (rd_data[0] !== 64'hBB) begin
      errors++; $display("FAIL rbw_new got %h want bb", rd_data[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    send_ar(16'h0000, 8'd15, 3'd3, 2'b01, 8'h44);
    ifc.rready = 1'b1;
    tick();
    tick();
    ifc.rready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ifc.rvalid !== 1'b0 || ifc.arready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got rvalid=%b arready=%b want 0 0", ifc.rvalid, ifc.arready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (ifc.arready !== 1'b1 || ifc.rvalid !== 1'b0 || ifc.awready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release got arready=%b rvalid=%b awready=%b want 1 0 1",
               ifc.arready, ifc.rvalid, ifc.awready);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp;
    logic [7:0] id;
    send_aw(16'h0700, 8'd0, 3'd3, 2'b01, 8'h01);
    send_w(64'h77, 8'hFF, 1'b1);
    get_b(resp, id);
    send_aw(16'h2008, 8'd0, 3'd3, 2'b01, 8'h02);
    send_w(64'h99, 8'hFF, 1'b1);
    get_b(resp, id);
    read_burst(16'h2700, 8'd0, 2'b01, 1'b0);
`ifdef AXI_RAM_DECERR_EN
    checks++;
    if (resp !== 2'b11) begin
      errors++; $display("FAIL decerr_b got %b want 11", resp);
    end
    checks++;
    if (rd_data[0] !== 64'h0 || rd_resp[0] !== 2'b11) begin
      errors++;
      $display("FAIL decerr_r got data=%h resp=%b want 0 11", rd_data[0], rd_resp[0]);
    end
`else
    checks++;
    if (resp !== 2'b00) begin
      errors++; $display("FAIL alias_b got %b want 00", resp);
    end
    checks++;
    if (rd_data[0] !== 64'h77 || rd_resp[0] !== 2'b00) begin
      errors++;
      $display("FAIL alias_r got data=%h resp=%b want 77 00", rd_data[0], rd_resp[0]);
    end
    read_burst(16'h0008, 8'd0, 2'b01, 1'b0);
    checks++;
    if (rd_data[0] !== 64'h99) begin
      errors++; $display("FAIL alias_w got %h want 99", rd_data[0]);
    end
`endif
  endtask

  initial begin
    ifc.awid = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = '0; ifc.awburst = '0;
    ifc.awlock = 1'b0; ifc.awcache = '0; ifc.awprot = '0; ifc.awvalid = 1'b0;
    ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 1'b0; ifc.wvalid = 1'b0; ifc.bready = 1'b0;
    ifc.arid = '0; ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = '0; ifc.arburst = '0;
    ifc.arlock = 1'b0; ifc.arcache = '0; ifc.arprot = '0; ifc.arvalid = 1'b0;
    ifc.rready = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_rready_toggle();
    test_strobe_and_errors();
    test_read_before_write();
    test_reset_mid_burst();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
